// File: rtl/alu.sv
// 32-bit registered ALU: combinational operation select feeding a result
// register and a zero flag that always describes the registered result.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  alu_control,
  output logic [31:0] result,
  output logic        zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1011;
  localparam logic [3:0] OP_LUI  = 4'b1100;
  localparam logic [3:0] OP_SLLV = 4'b1101;
  localparam logic [3:0] OP_SRLV = 4'b1110;
  localparam logic [3:0] OP_SRAV = 4'b1111;

  logic [4:0]  w_shamt;
  logic [4:0]  w_vsh;
  logic [31:0] w_next;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] r_result;
  logic        r_zero;

  // Immediate shifts take the amount from the shamt field of op2;
  // variable shifts take it from the low bits of op1 and shift op2.
  assign w_shamt = op2[10:6];
  assign w_vsh   = op1[4:0];
  assign w_slt   = $signed(op1) < $signed(op2);
  assign w_sltu  = op1 < op2;

  always_comb begin
    w_next = 32'h0000_0000;
    case (alu_control)
      OP_AND:  w_next = op1 & op2;
      OP_OR:   w_next = op1 | op2;
      OP_ADD:  w_next = op1 + op2;
      OP_ADDU: w_next = op1 + op2;
      OP_XOR:  w_next = op1 ^ op2;
      OP_NOR:  w_next = ~(op1 | op2);
      OP_SUB:  w_next = op1 - op2;
      OP_SLT:  w_next = {31'b0, w_slt};
      OP_SLTU: w_next = {31'b0, w_sltu};
      OP_SRA:  w_next = $unsigned($signed(op1) >>> w_shamt);
      OP_SRL:  w_next = op1 >> w_shamt;
      OP_SLL:  w_next = op1 << w_shamt;
      OP_LUI:  w_next = {op2[15:0], 16'h0000};
      OP_SLLV: w_next = op2 << w_vsh;
      OP_SRLV: w_next = op2 >> w_vsh;
      OP_SRAV: w_next = $unsigned($signed(op2) >>> w_vsh);
      default: w_next = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 32'h0000_0000;
      r_zero   <= 1'b1;
    end else begin
      r_result <= w_next;
      r_zero   <= (w_next == 32'h0000_0000);
    end
  end

  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios plus random operations
// compared against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_control;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;

  alu dut (
    .clk         (clk),
    .rst         (rst),
    .op1         (op1),
    .op2         (op2),
    .alu_control (alu_control),
    .result      (result),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference built from plain integer arithmetic: shifts are powers of two,
  // wrap-around is an explicit modulo, comparisons use widened integers.
  function automatic logic [31:0] ref_alu(input logic [3:0] ctl,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa, sb, p, m, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m  = longint'(1) << 32;
    r  = 0;
    case (ctl)
      4'd0:  r = ua & ub;
      4'd1:  r = ua | ub;
      4'd2, 4'd3: r = (ua + ub) % m;
      4'd4:  r = ua ^ ub;
      4'd5:  r = (m - 1) - (ua | ub);
      4'd6:  r = (ua + m - ub) % m;
      4'd7:  r = (sa < sb) ? 1 : 0;
      4'd8:  r = (ua < ub) ? 1 : 0;
      4'd9: begin
        p = longint'(1) << b[10:6];
        r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      end
      4'd10: begin p = longint'(1) << b[10:6]; r = ua / p; end
      4'd11: begin p = longint'(1) << b[10:6]; r = (ua * p) % m; end
      4'd12: r = ((ub % 65536) * 65536);
      4'd13: begin p = longint'(1) << a[4:0]; r = (ub * p) % m; end
      4'd14: begin p = longint'(1) << a[4:0]; r = ub / p; end
      default: begin
        p = longint'(1) << a[4:0];
        r = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
      end
    endcase
    r = ((r % m) + m) % m;
    return r[31:0];
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic [3:0] ctl,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    @(negedge clk);
    alu_control = ctl;
    op1 = a;
    op2 = b;
    exp = ref_alu(ctl, a, b);
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    rst = 1'b1;
    op1 = $urandom;
    op2 = $urandom;
    alu_control = 4'($urandom_range(0, 15));

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op1 = $urandom;
      op2 = $urandom;
      alu_control = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("reset.result", result, 32'h0);
      check("reset.zero", {31'b0, zero}, 32'h1);
    end
    @(negedge clk);
    rst = 1'b0;

    step("sra_sh0", 4'b1001, 32'h8000_0000, 32'h0000_0000);
    check("sra_sh0.const", result, 32'h8000_0000);
    step("sra_sh3", 4'b1001, 32'h8000_0000, 32'h0000_00C0);
    check("sra_sh3.const", result, 32'hF000_0000);
    step("lui", 4'b1100, 32'h0, 32'h0000_0010);
    check("lui.const", result, 32'h0010_0000);
    step("sub_eq", 4'b0110, 32'h1234_5678, 32'h1234_5678);
    check("sub_eq.zero", {31'b0, zero}, 32'h1);
    step("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    check("add_wrap.const", result, 32'h0);
    step("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt_neg.const", result, 32'h1);
    step("sltu_big", 4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
    check("sltu_big.const", result, 32'h0);

    // Reset wins over a live OR, then the first released edge loads it.
    @(negedge clk);
    rst = 1'b1;
    alu_control = 4'b0001;
    op1 = 32'hF0F0_F0F0;
    op2 = 32'h0;
    @(posedge clk);
    #1;
    check("rst_prio.result", result, 32'h0);
    check("rst_prio.zero", {31'b0, zero}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release.result", result, 32'hF0F0_F0F0);
    check("rst_release.zero", {31'b0, zero}, 32'h0);

    // Inputs changing between edges must not disturb the registered output.
    held = result;
    @(negedge clk);
    alu_control = 4'b0100;
    op1 = 32'hAAAA_5555;
    op2 = 32'h0F0F_0F0F;
    #2;
    check("midcycle.hold", result, held);
    op2 = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    check("midcycle.update", result, 32'hAAAA_5555 ^ 32'hFFFF_0000);

    // Shift boundaries: amount 0 and 31 for every shift flavour.
    for (int s = 0; s < 32; s += 31) begin
      ra = $urandom | 32'h8000_0000;
      rb = $urandom | 32'h8000_0001;
      step("sra_edge",  4'b1001, ra, (rb & ~32'h0000_07C0) | (32'(s) << 6));
      step("srl_edge",  4'b1010, ra, (rb & ~32'h0000_07C0) | (32'(s) << 6));
      step("sll_edge",  4'b1011, ra, (rb & ~32'h0000_07C0) | (32'(s) << 6));
      step("sllv_edge", 4'b1101, (ra & ~32'h1F) | 32'(s), rb);
      step("srlv_edge", 4'b1110, (ra & ~32'h1F) | 32'(s), rb);
      step("srav_edge", 4'b1111, (ra & ~32'h1F) | 32'(s), rb);
    end

    for (int i = 0; i < 400; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = 32'h0;
        2: rb = ~ra;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h0;
      step("random", rc, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
